vote_result_scanner: RTL and testbench
======================================

# vote_result_scanner

Downstream consumer of the voting machine's vote logger. In result mode it snapshots the per-candidate vote counters on request, scans them one candidate per cycle, and reports winner index, winner count, tie flag and total votes with a one-cycle done pulse. It feeds the result display and announcement logic and never alters the counters it reads.

## Interface

Parameters:
- NUM_CAND, 4, number of candidates (2..8)
- CNT_W, 8, width of each candidate vote counter

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- mode  input  1  1 = result mode, 0 = voting mode
- vote_counts  input  NUM_CAND*CNT_W  packed counters, candidate 0 in LSBs
- start  input  1  request a scan, level-sampled in IDLE
- busy  output  1  high from acceptance until done or abort
- done  output  1  one-cycle pulse, results valid and updated
- winner_id  output  $clog2(NUM_CAND)  index of highest-count candidate
- winner_votes  output  CNT_W  count of winner
- tie  output  1  another candidate equals winner_votes
- no_votes  output  1  all counters zero
- total_votes  output  CNT_W+$clog2(NUM_CAND)  sum of all counters

## Operation

- States: IDLE, SNAP, SCAN, DONE.
- IDLE: start=1 and mode=1 at a rising edge -> SNAP, busy=1. start with mode=0 is ignored.
- SNAP: capture vote_counts into an internal snapshot register; clear running max, idx, tie, sum -> SCAN, idx=0.
- SCAN: one candidate per cycle, ascending index.
  - count > max: max=count, best=idx, tie=0.
  - count == max and idx != 0: tie=1.
  - sum += count (full-width, cannot overflow).
  - After idx=NUM_CAND-1 -> DONE.
- DONE: register outputs from running values; no_votes = (sum==0); when no_votes, force tie=0, winner_id=0, winner_votes=0. Assert done for exactly this cycle -> IDLE, busy=0.
- Lowest index wins among equal maxima; tie still flags the equality.
- Abort: mode=0 sampled in SNAP or SCAN -> IDLE next edge, busy=0, no done, result outputs keep previous values.
- start while busy is ignored; there is no queueing.
- Snapshot isolates the scan from counter changes during SCAN.

## Timing

- Reset (async assert, sync release): state IDLE, busy=0, done=0, winner_id=0, winner_votes=0, tie=0, no_votes=0, total_votes=0, snapshot cleared.
- Latency: start sampled at edge E0 -> busy high after E0; done high during the cycle after edge E0+NUM_CAND+2 (E6 for NUM_CAND=4).
- Result outputs change only on the edge that raises done; they are stable otherwise.
- Back-to-back: start held high re-launches on the edge after done (IDLE accepts it), giving one scan per NUM_CAND+3 cycles.
- Reset asserted mid-scan: immediate return to reset values, no done.

## Structure

- Shared package vote_pkg: CNT_W default, candidate-id width function/constant, state enum type for this FSM.
- One combinational sub-module vote_max_step: takes current max/best/tie/sum and one count+idx, returns next values. Instantiated once, used by SCAN.
- No other sub-modules; snapshot, FSM and output registers live in the top.

## Test plan

- Counts {3,9,4,1} (cand0..3), mode=1, one-cycle start -> done 6 edges later; winner_id=1, winner_votes=9, tie=0, no_votes=0, total_votes=17.
- Counts {5,2,5,0} -> winner_id=0, winner_votes=5, tie=1, total_votes=12; {2,7,7,7} -> winner_id=1, tie=1.
- All counts 0 -> no_votes=1, tie=0, winner_id=0, winner_votes=0, total_votes=0; all 255 -> winner_id=0, tie=1, total_votes=1020.
- start with mode=0 -> busy never rises, no done; mode dropped during SCAN -> busy falls next edge, no done, prior results unchanged.
- Counts changed from {1,1,1,8} to {9,0,0,0} one cycle after SNAP -> result still winner_id=3, winner_votes=8, total_votes=11.
- reset pulled low during SCAN -> all outputs zero immediately; fresh start after release completes normally with correct results.

Source files
------------

// File: rtl/vote_pkg.sv
// vote_pkg: shared constants, id-width helper and scanner FSM state type.
package vote_pkg;
  localparam int CNT_W_DEF = 8;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef enum logic [1:0] {IDLE, SNAP, SCAN, DONE} scan_state_e;
endpackage

// File: rtl/vote_max_step.sv
// vote_max_step: one scan step folding a candidate count into running max/best/tie/sum.
module vote_max_step #(
  parameter int CNT_W = 8,
  parameter int IW    = 2,
  parameter int SW    = CNT_W + IW
) (
  input  logic [CNT_W-1:0] max_i,
  input  logic [IW-1:0]    best_i,
  input  logic             tie_i,
  input  logic [SW-1:0]    sum_i,
  input  logic [CNT_W-1:0] count,
  input  logic [IW-1:0]    idx,
  output logic [CNT_W-1:0] max_o,
  output logic [IW-1:0]    best_o,
  output logic             tie_o,
  output logic [SW-1:0]    sum_o
);
  logic gt, eq;
  always_comb begin
    gt     = count > max_i;
    eq     = (count == max_i) && (idx != '0);
    max_o  = gt ? count : max_i;
    best_o = gt ? idx : best_i;
    tie_o  = gt ? 1'b0 : (eq ? 1'b1 : tie_i);
    sum_o  = sum_i + SW'(count);
  end
endmodule

// File: rtl/vote_result_scanner.sv
// vote_result_scanner: snapshots vote counters, scans one candidate per cycle, reports winner/tie/total.
module vote_result_scanner
  import vote_pkg::*;
#(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = CNT_W_DEF,
  localparam int IW      = id_w(NUM_CAND),
  localparam int SW      = CNT_W + $clog2(NUM_CAND)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [NUM_CAND*CNT_W-1:0] vote_counts,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [IW-1:0]             winner_id,
  output logic [CNT_W-1:0]          winner_votes,
  output logic                      tie,
  output logic                      no_votes,
  output logic [SW-1:0]             total_votes
);
  scan_state_e               state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d, best_q, best_d, best_n, win_id_q, win_id_d;
  logic [NUM_CAND*CNT_W-1:0] snap_q, snap_d;
  logic [CNT_W-1:0]          max_q, max_d, max_n, win_votes_q, win_votes_d, cur_cnt;
  logic                      run_tie_q, run_tie_d, tie_n, tie_q, tie_d;
  logic                      done_q, done_d, no_votes_q, no_votes_d;
  logic [SW-1:0]             sum_q, sum_d, sum_n, total_q, total_d;

  assign cur_cnt = snap_q[CNT_W*int'(idx_q) +: CNT_W];

  vote_max_step #(.CNT_W(CNT_W), .IW(IW), .SW(SW)) u_step (
    .max_i(max_q), .best_i(best_q), .tie_i(run_tie_q), .sum_i(sum_q),
    .count(cur_cnt), .idx(idx_q),
    .max_o(max_n), .best_o(best_n), .tie_o(tie_n), .sum_o(sum_n)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    max_d       = max_q;
    best_d      = best_q;
    run_tie_d   = run_tie_q;
    sum_d       = sum_q;
    done_d      = 1'b0;
    win_id_d    = win_id_q;
    win_votes_d = win_votes_q;
    tie_d       = tie_q;
    no_votes_d  = no_votes_q;
    total_d     = total_q;
    case (state_q)
      IDLE: state_d = (start && mode) ? SNAP : IDLE;
      SNAP: begin
        state_d   = mode ? SCAN : IDLE;
        snap_d    = mode ? vote_counts : snap_q;
        max_d     = '0;
        best_d    = '0;
        run_tie_d = 1'b0;
        sum_d     = '0;
        idx_d     = '0;
      end
      SCAN: begin
        state_d   = !mode ? IDLE : (idx_q == IW'(NUM_CAND-1)) ? DONE : SCAN;
        max_d     = max_n;
        best_d    = best_n;
        run_tie_d = tie_n;
        sum_d     = sum_n;
        idx_d     = idx_q + 1'b1;
      end
      DONE: begin
        state_d     = IDLE;
        done_d      = 1'b1;
        no_votes_d  = (sum_q == '0);
        win_id_d    = no_votes_d ? '0 : best_q;
        win_votes_d = no_votes_d ? '0 : max_q;
        tie_d       = no_votes_d ? 1'b0 : run_tie_q;
        total_d     = sum_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      snap_q      <= '0;
      max_q       <= '0;
      best_q      <= '0;
      run_tie_q   <= 1'b0;
      sum_q       <= '0;
      done_q      <= 1'b0;
      win_id_q    <= '0;
      win_votes_q <= '0;
      tie_q       <= 1'b0;
      no_votes_q  <= 1'b0;
      total_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      max_q       <= max_d;
      best_q      <= best_d;
      run_tie_q   <= run_tie_d;
      sum_q       <= sum_d;
      done_q      <= done_d;
      win_id_q    <= win_id_d;
      win_votes_q <= win_votes_d;
      tie_q       <= tie_d;
      no_votes_q  <= no_votes_d;
      total_q     <= total_d;
    end
  end

  assign busy         = state_q != IDLE;
  assign done         = done_q;
  assign winner_id    = win_id_q;
  assign winner_votes = win_votes_q;
  assign tie          = tie_q;
  assign no_votes     = no_votes_q;
  assign total_votes  = total_q;
endmodule

// File: tb/tb_vote_result_scanner.sv
// tb_vote_result_scanner: directed vectors with hand-computed results for vote_result_scanner.
module tb_vote_result_scanner;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mode = 1'b0;
  logic        start = 1'b0;
  logic [31:0] vote_counts = '0;
  logic        busy, done, tie, no_votes;
  logic [1:0]  winner_id;
  logic [7:0]  winner_votes;
  logic [9:0]  total_votes;
  int          total = 0;
  int          bad = 0;

  vote_result_scanner #(.NUM_CAND(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .mode(mode), .vote_counts(vote_counts),
    .start(start), .busy(busy), .done(done), .winner_id(winner_id),
    .winner_votes(winner_votes), .tie(tie), .no_votes(no_votes),
    .total_votes(total_votes)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int c0, input int c1, input int c2, input int c3);
    return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  task automatic check_res(input string tag, input int wid, input int wv, input int te,
                           input int nv, input int tot);
    chk({tag, ".winner_id"}, 32'(winner_id), wid);
    chk({tag, ".winner_votes"}, 32'(winner_votes), wv);
    chk({tag, ".tie"}, 32'(tie), te);
    chk({tag, ".no_votes"}, 32'(no_votes), nv);
    chk({tag, ".total_votes"}, 32'(total_votes), tot);
  endtask

  task automatic scan(input string tag, input logic [31:0] cnt, input bit chg, input logic [31:0] cnt2,
                      input int wid, input int wv, input int te, input int nv, input int tot);
    int n;
    vote_counts = cnt;
    mode = 1'b1;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    chk({tag, ".busy_on"}, 32'(busy), 1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 1 && chg) vote_counts = cnt2;
    end while (!done && n < 20);
    chk({tag, ".latency"}, n, 6);
    chk({tag, ".busy_off"}, 32'(busy), 0);
    check_res(tag, wid, wv, te, nv, tot);
    @(negedge clock);
    chk({tag, ".done_pulse"}, 32'(done), 0);
  endtask

  initial begin
    int seen;
    repeat (2) @(negedge clock);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    check_res("rst", 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clock);

    scan("basic", pack(3, 9, 4, 1), 0, 0, 1, 9, 0, 0, 17);
    scan("tie0", pack(5, 2, 5, 0), 0, 0, 0, 5, 1, 0, 12);
    scan("tie1", pack(2, 7, 7, 7), 0, 0, 1, 7, 1, 0, 23);
    scan("zero", pack(0, 0, 0, 0), 0, 0, 0, 0, 0, 1, 0);
    scan("full", pack(255, 255, 255, 255), 0, 0, 0, 255, 1, 0, 1020);
    scan("snap", pack(1, 1, 1, 8), 1, pack(9, 0, 0, 0), 3, 8, 0, 0, 11);

    // start in voting mode must be ignored
    mode = 1'b0;
    start = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (busy || done) seen++;
    end
    start = 1'b0;
    chk("vmode.ignored", seen, 0);

    // abort mid-scan keeps prior results
    mode = 1'b1;
    vote_counts = pack(0, 0, 50, 0);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("abort.busy_scan", 32'(busy), 1);
    mode = 1'b0;
    @(negedge clock);
    chk("abort.busy_off", 32'(busy), 0);
    seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (done) seen++;
    end
    chk("abort.no_done", seen, 0);
    check_res("abort", 3, 8, 0, 0, 11);

    // back-to-back with start held high
    mode = 1'b1;
    vote_counts = pack(3, 9, 4, 1);
    @(negedge clock) start = 1'b1;
    seen = 0;
    while (!done && seen < 20) begin
      @(negedge clock);
      seen++;
    end
    seen = 0;
    do begin
      @(negedge clock);
      seen++;
    end while (!done && seen < 20);
    chk("b2b.period", seen, 7);
    check_res("b2b", 1, 9, 0, 0, 17);
    start = 1'b0;
    repeat (8) @(negedge clock);

    // reset mid-scan
    vote_counts = pack(0, 4, 0, 6);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.done", 32'(done), 0);
    check_res("midrst", 0, 0, 0, 0, 0);
    @(negedge clock) reset = 1'b1;
    scan("after_rst", pack(0, 4, 0, 6), 0, 0, 3, 6, 0, 0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
